// File: rtl/paddle_position.sv
// paddle_position
//   Turns the wrapping 8-bit click count from the quadrature decoder into a
//   clamped vertical paddle position. On each FRAME_TICK the block runs one
//   pass of DELTA -> SCALE -> APPLY:
//     DELTA : signed 8-bit click delta since the previous pass
//     SCALE : delta * 2^STEP_SHIFT, saturated to +/-MAX_STEP, optional invert
//     APPLY : add to PADDLE_Y and clamp to [Y_MIN, Y_MAX - PADDLE_H]
//   CENTER overrides everything and snaps the paddle back to mid-screen.
//
// Handshake: there is no ready/valid pair. FRAME_TICK is a request pulse that
//   is never dropped: in IDLE it starts a pass, otherwise it is remembered as
//   a single pending pass (any number of ticks merge). UPDATED is a one-cycle
//   pulse in the cycle after a pass or recentre lands in PADDLE_Y. BUSY is
//   high whenever a pass is in flight.
//
// Ports:
//   CLOCK      in   system clock, rising edge
//   RESET      in   asynchronous active-high reset
//   COUNT      in   [7:0] encoder click count, wraps modulo 256
//   FRAME_TICK in   one-cycle pulse at start of vertical blank
//   CENTER     in   synchronous recentre request, level-sampled
//   PADDLE_Y   out  [9:0] paddle top row in pixels
//   UPDATED    out  one-cycle pulse after a pass or recentre
//   BUSY       out  high while state != IDLE
//   STATE      out  [1:0] current FSM state (debug observation)

module paddle_position #(
  parameter int Y_MIN      = 0,
  parameter int Y_MAX      = 480,
  parameter int PADDLE_H   = 64,
  parameter int STEP_SHIFT = 2,
  parameter int MAX_STEP   = 32,
  parameter int INVERT     = 0
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic [7:0] COUNT,
  input  logic       FRAME_TICK,
  input  logic       CENTER,
  output logic [9:0] PADDLE_Y,
  output logic       UPDATED,
  output logic       BUSY,
  output logic [1:0] STATE
);

  localparam int Y_HI  = Y_MAX - PADDLE_H;
  localparam int Y_CTR = (Y_MIN + Y_HI) / 2;

  localparam logic [9:0]         Y_MIN_V  = 10'(Y_MIN);
  localparam logic [9:0]         Y_HI_V   = 10'(Y_HI);
  localparam logic [9:0]         Y_CTR_V  = 10'(Y_CTR);
  localparam logic signed [11:0] Y_MIN_S  = 12'(Y_MIN);
  localparam logic signed [11:0] Y_HI_S   = 12'(Y_HI);
  localparam logic signed [11:0] STEP_LIM = 12'(MAX_STEP);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DELTA = 2'd1,
    S_SCALE = 2'd2,
    S_APPLY = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [7:0]          sample, sample_nxt;
  logic [7:0]          last_count, last_nxt;
  logic                primed, primed_nxt;
  logic                pending, pending_nxt;
  logic signed [7:0]   delta_r, delta_nxt;
  logic signed [11:0]  step_r, step_nxt;
  logic [9:0]          paddle_y, y_nxt;
  logic                updated, updated_nxt;

  logic signed [11:0]  delta_ext;
  logic signed [11:0]  step_shift;
  logic signed [11:0]  step_sat;
  logic signed [11:0]  step_dir;
  logic signed [11:0]  sum;
  logic [9:0]          y_clamped;

  always_comb begin
    state_nxt   = state;
    sample_nxt  = sample;
    last_nxt    = last_count;
    primed_nxt  = primed;
    pending_nxt = pending;
    delta_nxt   = delta_r;
    step_nxt    = step_r;
    y_nxt       = paddle_y;
    updated_nxt = 1'b0;

    // Scaling datapath, consumed in SCALE.
    delta_ext  = {{4{delta_r[7]}}, delta_r};
    step_shift = delta_ext <<< STEP_SHIFT;
    if (step_shift > STEP_LIM) begin
      step_sat = STEP_LIM;
    end else if (step_shift < -STEP_LIM) begin
      step_sat = -STEP_LIM;
    end else begin
      step_sat = step_shift;
    end
    step_dir = (INVERT != 0) ? -step_sat : step_sat;

    // Position datapath, consumed in APPLY. Widening to 12-bit signed lets
    // an upward move past the top show up as negative before clamping.
    sum = $signed({2'b00, paddle_y}) + step_r;
    if (sum < Y_MIN_S) begin
      y_clamped = Y_MIN_V;
    end else if (sum > Y_HI_S) begin
      y_clamped = Y_HI_V;
    end else begin
      y_clamped = sum[9:0];
    end

    case (state)
      S_IDLE: begin
        if (FRAME_TICK) begin
          sample_nxt = COUNT;
          state_nxt  = S_DELTA;
        end
      end
      S_DELTA: begin
        if (FRAME_TICK) pending_nxt = 1'b1;
        // The first pass after reset only records the baseline.
        delta_nxt  = primed ? (sample - last_count) : 8'd0;
        last_nxt   = sample;
        primed_nxt = 1'b1;
        state_nxt  = S_SCALE;
      end
      S_SCALE: begin
        if (FRAME_TICK) pending_nxt = 1'b1;
        step_nxt  = step_dir;
        state_nxt = S_APPLY;
      end
      S_APPLY: begin
        y_nxt       = y_clamped;
        updated_nxt = 1'b1;
        // A tick landing in APPLY is treated as pending; the follow-on pass
        // captures COUNT on this same edge and skips IDLE.
        if (pending || FRAME_TICK) begin
          sample_nxt  = COUNT;
          pending_nxt = 1'b0;
          state_nxt   = S_DELTA;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Recentre wins over everything, including a coincident FRAME_TICK and
    // any pass in flight.
    if (CENTER) begin
      y_nxt       = Y_CTR_V;
      last_nxt    = COUNT;
      primed_nxt  = 1'b1;
      pending_nxt = 1'b0;
      state_nxt   = S_IDLE;
      updated_nxt = 1'b1;
    end
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state      <= S_IDLE;
      sample     <= 8'd0;
      last_count <= 8'd0;
      primed     <= 1'b0;
      pending    <= 1'b0;
      delta_r    <= 8'sd0;
      step_r     <= 12'sd0;
      paddle_y   <= Y_CTR_V;
      updated    <= 1'b0;
    end else begin
      state      <= state_nxt;
      sample     <= sample_nxt;
      last_count <= last_nxt;
      primed     <= primed_nxt;
      pending    <= pending_nxt;
      delta_r    <= delta_nxt;
      step_r     <= step_nxt;
      paddle_y   <= y_nxt;
      updated    <= updated_nxt;
    end
  end

  assign PADDLE_Y = paddle_y;
  assign UPDATED  = updated;
  assign BUSY     = (state != S_IDLE);
  assign STATE    = state;

endmodule
